// File: rtl/data_mem_arb.sv
// Two-port arbiter for the shared OBI data-memory port with in-order response routing.
// `DATA_ARB_RR_EN selects round-robin; default is port-0 priority with a starvation guard.
module data_mem_arb #(
  parameter int unsigned MAX_OUTST  = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s0_req,
  input  logic        s0_we,
  input  logic [3:0]  s0_be,
  input  logic        s0_is_cap,
  input  logic [31:0] s0_addr,
  input  logic [32:0] s0_wdata,
  input  logic [7:0]  s0_flag,
  input  logic        s1_req,
  input  logic        s1_we,
  input  logic [3:0]  s1_be,
  input  logic        s1_is_cap,
  input  logic [31:0] s1_addr,
  input  logic [32:0] s1_wdata,
  input  logic [7:0]  s1_flag,
  output logic        s0_gnt,
  output logic        s1_gnt,
  output logic        s0_rvalid,
  output logic        s1_rvalid,
  output logic [32:0] s_rdata,
  output logic        s_err,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic        m_is_cap,
  output logic [31:0] m_addr,
  output logic [32:0] m_wdata,
  output logic [7:0]  m_flag,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [32:0] m_rdata,
  input  logic        m_err,
  output logic        resp_orphan
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic                 sel_q, sel_d;
  logic                 lock_q, orphan_q;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [MAX_OUTST-1:0] fifo_q;
  logic                 full, empty, push, pop;
  logic                 head, both, sel_req, prio1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef DATA_ARB_RR_EN
  logic last_q;
  assign prio1 = ~last_q;
`else
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;
  assign prio1 = (starve_q == SW'(STARVE_MAX));
`endif

  assign both  = s0_req & s1_req;
  assign full  = (count_q == CW'(MAX_OUTST));
  assign empty = (count_q == '0);

  always_comb begin
    sel_d = sel_q;
    priority case (1'b1)
      lock_q:  sel_d = sel_q;
      both:    sel_d = prio1;
      s0_req:  sel_d = 1'b0;
      s1_req:  sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  assign sel_req  = sel_d ? s1_req : s0_req;
  assign m_req    = rst_ni & sel_req & ~full;
  assign m_we     = sel_d ? s1_we     : s0_we;
  assign m_be     = sel_d ? s1_be     : s0_be;
  assign m_is_cap = sel_d ? s1_is_cap : s0_is_cap;
  assign m_addr   = sel_d ? s1_addr   : s0_addr;
  assign m_wdata  = sel_d ? s1_wdata  : s0_wdata;
  assign m_flag   = sel_d ? s1_flag   : s0_flag;

  assign s0_gnt = m_gnt & m_req & ~sel_d;
  assign s1_gnt = m_gnt & m_req & sel_d;

  assign push = m_req & m_gnt;
  assign pop  = rst_ni & m_rvalid & ~empty;
  assign head = fifo_q[rptr_q];

  assign s_rdata     = m_rdata;
  assign s_err       = m_err;
  assign s0_rvalid   = pop & ~head;
  assign s1_rvalid   = pop & head;
  assign resp_orphan = orphan_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q    <= 1'b0;
      lock_q   <= 1'b0;
      orphan_q <= 1'b0;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fifo_q   <= '0;
    end else begin
      sel_q   <= sel_d;
      // A dropped request releases the lock too, not just a grant.
      lock_q  <= m_req & ~m_gnt;
      count_q <= count_d;
      if (push) begin
        fifo_q[wptr_q] <= sel_d;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (m_rvalid & empty) orphan_q <= 1'b1;
    end
  end

`ifdef DATA_ARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b0;
    end else if (push) begin
      last_q <= sel_d;
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (s1_gnt) begin
      starve_q <= '0;
    end else if (s0_gnt & s1_req & ~prio1) begin
      starve_q <= starve_q + SW'(1);
    end
  end
`endif

endmodule
